// File: rtl/input_cond_pkg.sv
//------------------------------------------------------------------------------
// input_cond_pkg
//   Shared constants and types for the input conditioner: channel count,
//   reset (inactive) level of every raw input, default debounce length and
//   the packed channel-vector layout used to route the 12 debounce cells.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package input_cond_pkg;

  localparam int NUM_SW = 8;
  // sw[7:0] + stop + ctrl + key1 + key2
  localparam int NUM_CH = NUM_SW + 4;

  // Inactive levels loaded into synchronisers and stable registers on reset
  localparam logic STOP_RST = 1'b1;
  localparam logic CTRL_RST = 1'b0;
  localparam logic SW_RST   = 1'b0;
  localparam logic KEY_RST  = 1'b1;

  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // Bit layout of every per-channel vector: sw occupies bits [7:0]
  typedef struct packed {
    logic              key2;
    logic              key1;
    logic              ctrl;
    logic              stop;
    logic [NUM_SW-1:0] sw;
  } chan_vec_t;

  function automatic chan_vec_t rst_levels();
    chan_vec_t v;
    v.key2 = KEY_RST;
    v.key1 = KEY_RST;
    v.ctrl = CTRL_RST;
    v.stop = STOP_RST;
    v.sw   = {NUM_SW{SW_RST}};
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_cell.sv
//------------------------------------------------------------------------------
// debounce_cell
//   One input channel: SYNC_STAGES-deep synchroniser followed by a
//   stable-level register that only follows the synchronised input after it
//   has differed from the stable level on DEBOUNCE_CYCLES consecutive edges.
//   Ports:
//     ck   in  system clock, rising edge
//     clr  in  asynchronous active-low reset
//     din  in  raw (asynchronous) input
//     dout out debounced stable level
//     rise out one-cycle strobe, high the cycle dout is newly 1
//     fall out one-cycle strobe, high the cycle dout is newly 0
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_cell #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   CNT_W           = 20,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic ck,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_st;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // cnt==0 is the idle state; any non-zero count means a candidate new level
  // has been seen on that many consecutive edges. A single matching sample
  // drops back to idle, which is what rejects short glitches.
  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_st   <= RST_VAL;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_st) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_st   <= w_s;
        r_cnt  <= '0;
        r_rise <= w_s;
        r_fall <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_st;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
//------------------------------------------------------------------------------
// input_conditioner
//   Synchronises and debounces every raw board input (stop, ctrl, sw[7:0],
//   key1, key2) and produces clean levels, a switch-change strobe and
//   one-cycle press pulses for the two push-buttons.
//   Ports:
//     ck, clr               clock (rising edge), async active-low reset
//     stop, ctrl, sw[7:0]   raw switches
//     key1, key2            raw push-buttons, active-low
//     stop_lvl, ctrl_lvl    debounced switch levels
//     sw_lvl[7:0]           debounced switch levels
//     sw_chg                one-cycle strobe after any sw_lvl change
//     key1/2_press          one-cycle pulse per accepted press
//     key1/2_held           debounced key pressed, active-high
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic              ck,
  input  logic              clr,
  input  logic              stop,
  input  logic              ctrl,
  input  logic [NUM_SW-1:0] sw,
  input  logic              key1,
  input  logic              key2,
  output logic              stop_lvl,
  output logic              ctrl_lvl,
  output logic [NUM_SW-1:0] sw_lvl,
  output logic              sw_chg,
  output logic              key1_press,
  output logic              key2_press,
  output logic              key1_held,
  output logic              key2_held
);

  localparam chan_vec_t c_RST_LVL = rst_levels();

  chan_vec_t         w_raw;
  logic [NUM_CH-1:0] w_lvl_v;
  logic [NUM_CH-1:0] w_rise_v;
  logic [NUM_CH-1:0] w_fall_v;
  chan_vec_t         w_lvl;
  chan_vec_t         w_rise;
  chan_vec_t         w_fall;

  logic r_sw_chg;
  logic r_key1_press;
  logic r_key2_press;

  assign w_raw.key2 = key2;
  assign w_raw.key1 = key1;
  assign w_raw.ctrl = ctrl;
  assign w_raw.stop = stop;
  assign w_raw.sw   = sw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RST_VAL         (c_RST_LVL[i])
    ) u_db (
      .ck   (ck),
      .clr  (clr),
      .din  (w_raw[i]),
      .dout (w_lvl_v[i]),
      .rise (w_rise_v[i]),
      .fall (w_fall_v[i])
    );
  end

  assign w_lvl  = chan_vec_t'(w_lvl_v);
  assign w_rise = chan_vec_t'(w_rise_v);
  assign w_fall = chan_vec_t'(w_fall_v);

  // Keys are active-low, so a press is a fall of the stable level. The cell
  // strobes are already registered; registering again keeps every output a
  // flop and lands the pulse in the cycle after the level change.
  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      r_sw_chg     <= 1'b0;
      r_key1_press <= 1'b0;
      r_key2_press <= 1'b0;
    end else begin
      r_sw_chg     <= |(w_rise.sw | w_fall.sw);
      r_key1_press <= w_fall.key1;
      r_key2_press <= w_fall.key2;
    end
  end

  assign stop_lvl   = w_lvl.stop;
  assign ctrl_lvl   = w_lvl.ctrl;
  assign sw_lvl     = w_lvl.sw;
  assign key1_held  = ~w_lvl.key1;
  assign key2_held  = ~w_lvl.key2;
  assign sw_chg     = r_sw_chg;
  assign key1_press = r_key1_press;
  assign key2_press = r_key2_press;

  // Edge strobes of the non-sw level channels and key releases have no consumer
  logic w_unused;
  assign w_unused = ^{w_rise.stop, w_fall.stop, w_rise.ctrl, w_fall.ctrl,
                      w_rise.key1, w_rise.key2};

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
//------------------------------------------------------------------------------
// tb_input_conditioner
//   Directed bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
//   20 ns clock). Level outputs are checked at fixed edges after each input
//   change; pulse outputs are checked every cycle against a queue of
//   expected pulse events pushed when the stimulus is driven.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_input_conditioner;

  logic       ck;
  logic       clr;
  logic       stop;
  logic       ctrl;
  logic [7:0] sw;
  logic       key1;
  logic       key2;
  logic       stop_lvl;
  logic       ctrl_lvl;
  logic [7:0] sw_lvl;
  logic       sw_chg;
  logic       key1_press;
  logic       key2_press;
  logic       key1_held;
  logic       key2_held;

  input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20)
  ) dut (
    .ck         (ck),
    .clr        (clr),
    .stop       (stop),
    .ctrl       (ctrl),
    .sw         (sw),
    .key1       (key1),
    .key2       (key2),
    .stop_lvl   (stop_lvl),
    .ctrl_lvl   (ctrl_lvl),
    .sw_lvl     (sw_lvl),
    .sw_chg     (sw_chg),
    .key1_press (key1_press),
    .key2_press (key2_press),
    .key1_held  (key1_held),
    .key2_held  (key2_held)
  );

  initial ck = 1'b0;
  always #10 ck = ~ck;

  // Expected pulse event: cycle index and {sw_chg, key2_press, key1_press}
  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } pulse_t;

  pulse_t exp_q[$];
  int     ncyc;
  int     n_chk;
  int     n_fail;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected pulse n cycles after the current sample point (ncyc)
  task automatic push(input int n, input logic [2:0] kind);
    pulse_t p;
    p.cyc  = ncyc + n;
    p.kind = kind;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == p.cyc)
      exp_q[exp_q.size()-1].kind = exp_q[exp_q.size()-1].kind | kind;
    else
      exp_q.push_back(p);
  endtask

  // Advance n cycles; sample on the falling edge and score the pulse outputs
  task automatic tick(input int n);
    logic [2:0] obs;
    logic [2:0] exp;
    for (int k = 0; k < n; k++) begin
      @(negedge ck);
      ncyc++;
      obs = {sw_chg, key2_press, key1_press};
      exp = 3'b000;
      if (exp_q.size() > 0 && exp_q[0].cyc == ncyc) begin
        exp = exp_q[0].kind;
        void'(exp_q.pop_front());
      end
      n_chk++;
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL pulse@cyc%0d: observed {chg,k2,k1}=%b expected=%b", ncyc, obs, exp);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ncyc   = 0;
    clr    = 1'b1;
    stop   = 1'b1;
    ctrl   = 1'b0;
    sw     = 8'hFF;
    key1   = 1'b0;
    key2   = 1'b1;
    #1 clr = 1'b0;

    // Reset with key1 pressed and all switches up: outputs stay inactive
    tick(3);
    chk("rst_stop_lvl",  8'(stop_lvl),  8'h01);
    chk("rst_ctrl_lvl",  8'(ctrl_lvl),  8'h00);
    chk("rst_sw_lvl",    sw_lvl,        8'h00);
    chk("rst_key1_held", 8'(key1_held), 8'h00);
    chk("rst_key2_held", 8'(key2_held), 8'h00);

    // Release: levels appear at edge 6, one key1_press + one sw_chg at edge 7
    clr = 1'b1;
    push(7, 3'b101);
    tick(5);
    chk("rel_sw_lvl_e5",    sw_lvl,        8'h00);
    chk("rel_key1_held_e5", 8'(key1_held), 8'h00);
    tick(1);
    chk("rel_sw_lvl_e6",    sw_lvl,        8'hFF);
    chk("rel_key1_held_e6", 8'(key1_held), 8'h01);
    tick(3);

    // Switches down and key1 released together: one sw_chg, no key pulse
    sw   = 8'h00;
    key1 = 1'b1;
    push(7, 3'b100);
    tick(6);
    chk("clr_sw_lvl",    sw_lvl,        8'h00);
    chk("clr_key1_held", 8'(key1_held), 8'h00);
    tick(4);

    // ctrl 0->1 held, then back to 0 after 11 cycles
    ctrl = 1'b1;
    tick(5);
    chk("ctrl_up_e5", 8'(ctrl_lvl), 8'h00);
    tick(1);
    chk("ctrl_up_e6", 8'(ctrl_lvl), 8'h01);
    tick(5);
    ctrl = 1'b0;
    tick(5);
    chk("ctrl_dn_e5", 8'(ctrl_lvl), 8'h01);
    tick(1);
    chk("ctrl_dn_e6", 8'(ctrl_lvl), 8'h00);
    tick(2);

    // stop switch 1->0 and back
    stop = 1'b0;
    tick(5);
    chk("stop_dn_e5", 8'(stop_lvl), 8'h01);
    tick(1);
    chk("stop_dn_e6", 8'(stop_lvl), 8'h00);
    stop = 1'b1;
    tick(6);
    chk("stop_up_e6", 8'(stop_lvl), 8'h01);
    tick(2);

    // key2 bounce: 3 cycles low is rejected
    key2 = 1'b0;
    tick(3);
    key2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("k2_bounce_held", 8'(key2_held), 8'h00);
    end

    // key2 low for 10 cycles: exactly one press, release gives no pulse
    key2 = 1'b0;
    push(7, 3'b010);
    tick(5);
    chk("k2_held_e5", 8'(key2_held), 8'h00);
    tick(1);
    chk("k2_held_e6", 8'(key2_held), 8'h01);
    tick(4);
    key2 = 1'b1;
    tick(6);
    chk("k2_released", 8'(key2_held), 8'h00);
    tick(2);

    // Both keys fall together and are held 20 cycles: one shared pulse cycle
    key1 = 1'b0;
    key2 = 1'b0;
    push(7, 3'b011);
    tick(6);
    chk("both_k1_held", 8'(key1_held), 8'h01);
    chk("both_k2_held", 8'(key2_held), 8'h01);
    tick(14);
    key1 = 1'b1;
    key2 = 1'b1;
    tick(8);

    // sw 00->81 in one cycle: single strobe; then only sw[3] toggles
    sw = 8'h81;
    push(7, 3'b100);
    tick(5);
    chk("sw81_e5", sw_lvl, 8'h00);
    tick(1);
    chk("sw81_e6", sw_lvl, 8'h81);
    tick(3);
    sw = 8'h89;
    push(7, 3'b100);
    tick(6);
    chk("sw89_e6", sw_lvl, 8'h89);
    tick(3);

    // Reset at edge 3 of a key1 debounce; key stays low through release
    key1 = 1'b0;
    tick(3);
    clr = 1'b0;
    sw  = 8'h00;
    exp_q.delete();
    tick(2);
    chk("mid_rst_stop_lvl",  8'(stop_lvl),  8'h01);
    chk("mid_rst_ctrl_lvl",  8'(ctrl_lvl),  8'h00);
    chk("mid_rst_sw_lvl",    sw_lvl,        8'h00);
    chk("mid_rst_key1_held", 8'(key1_held), 8'h00);
    clr = 1'b1;
    push(7, 3'b001);
    tick(5);
    chk("post_rst_k1_e5", 8'(key1_held), 8'h00);
    tick(1);
    chk("post_rst_k1_e6", 8'(key1_held), 8'h01);
    tick(1);
    key1 = 1'b1;
    tick(8);
    chk("post_rst_k1_rel", 8'(key1_held), 8'h00);

    // Every expected pulse must have been consumed
    chk("pulse_queue_empty", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
